// File: rtl/transport_pkg.sv
// Shared types and default constants for the beat-looper transport.
package transport_pkg;

    localparam int unsigned TEMPO_W_DEF       = 33;
    localparam int unsigned TEMPO_DEFAULT_DEF = 1687500;
    localparam int unsigned TEMPO_MIN_DEF     = 687500;
    localparam int unsigned TEMPO_MAX_DEF     = 4687500;
    localparam int unsigned STEP_W_DEF        = 7;
    localparam int unsigned BAR_STEPS_DEF     = 16;

    typedef enum logic [2:0] {
        ST_STOPPED   = 3'd0,
        ST_PAUSED    = 3'd1,
        ST_COUNT_IN  = 3'd2,
        ST_PLAYING   = 3'd3,
        ST_ARMED     = 3'd4,
        ST_RECORDING = 3'd5
    } state_e;

    // States in which the step timer counts
    function automatic logic timer_runs(input state_e s);
        return (s == ST_COUNT_IN) || (s == ST_PLAYING) ||
               (s == ST_ARMED)    || (s == ST_RECORDING);
    endfunction

    // States in which the loop is audibly advancing
    function automatic logic is_playing(input state_e s);
        return (s == ST_PLAYING) || (s == ST_ARMED) || (s == ST_RECORDING);
    endfunction

endpackage

// File: rtl/transport_controller_step_timer.sv
// Loadable down-counter that fires a tick each time it expires while running.
module step_timer #(
    parameter int unsigned W = 33
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         run_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Expiry is a pure function of the count so the FSM can react in the same cycle
    assign tick_c = run_i && (cnt_q == '0);

    // Next count: clear beats load beats normal countdown/reload
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (run_i) begin
            if (cnt_q == '0) begin
                cnt_d = load_val_i;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/transport_controller.sv
// Transport FSM, tempo register and step counter for the beat looper.
module transport_controller
    import transport_pkg::*;
#(
    parameter int unsigned TEMPO_W       = TEMPO_W_DEF,
    parameter int unsigned TEMPO_DEFAULT = TEMPO_DEFAULT_DEF,
    parameter int unsigned TEMPO_MIN     = TEMPO_MIN_DEF,
    parameter int unsigned TEMPO_MAX     = TEMPO_MAX_DEF,
    parameter int unsigned STEP_W        = STEP_W_DEF,
    parameter int unsigned BAR_STEPS     = BAR_STEPS_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               play_btn,
    input  logic               stop_btn,
    input  logic               rec_btn,
    input  logic               faster,
    input  logic               slower,
    output logic [STEP_W-1:0]  step,
    output logic               step_tick,
    output logic               loop_wrap,
    output logic               playing,
    output logic               recording,
    output logic               armed,
    output logic               count_in,
    output logic [TEMPO_W-1:0] tempo
);

    localparam int unsigned        CIN_W     = $clog2(BAR_STEPS) + 1;
    localparam logic [CIN_W-1:0]   CIN_LAST  = CIN_W'(BAR_STEPS - 1);
    localparam logic [STEP_W-1:0]  BAR_MASK  = STEP_W'(BAR_STEPS - 1);
    localparam logic [TEMPO_W-1:0] TEMPO_RST = TEMPO_W'(TEMPO_DEFAULT);
    localparam logic [TEMPO_W-1:0] TEMPO_LO  = TEMPO_W'(TEMPO_MIN);
    localparam logic [TEMPO_W-1:0] TEMPO_HI  = TEMPO_W'(TEMPO_MAX);

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d, step_next_c;
    logic [CIN_W-1:0]   cin_q, cin_d;
    logic [TEMPO_W-1:0] tempo_q, tempo_d;
    logic               advance_c;
    logic               tick_c;
    logic               step_tick_q, loop_wrap_q;
    logic               playing_q, recording_q, armed_q, count_in_q;

    step_timer #(
        .W (TEMPO_W)
    ) u_step_timer (
        .clock      (clock),
        .resetn     (resetn),
        .run_i      (timer_runs(state_q)),
        .load_i     (!timer_runs(state_q) && timer_runs(state_d)),
        .clear_i    (stop_btn),
        .load_val_i (tempo_q),
        .tick_c     (tick_c)
    );

    assign step_next_c = step_q + STEP_W'(1);

    // Saturating tempo nudge; opposing or absent requests hold
    always_comb begin
        tempo_d = tempo_q;
        if (faster && !slower && (tempo_q > TEMPO_LO)) begin
            tempo_d = tempo_q - TEMPO_W'(1);
        end else if (slower && !faster && (tempo_q < TEMPO_HI)) begin
            tempo_d = tempo_q + TEMPO_W'(1);
        end
    end

    // Transport next-state: stop > play > rec, then timer ticks
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cin_d     = cin_q;
        advance_c = 1'b0;
        if (stop_btn) begin
            state_d = ST_STOPPED;
            step_d  = '0;
            cin_d   = '0;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    if (play_btn) begin
                        state_d = ST_PLAYING;
                    end else if (rec_btn) begin
                        state_d = ST_COUNT_IN;
                        cin_d   = '0;
                    end
                end
                ST_PAUSED: begin
                    if (play_btn) state_d = ST_PLAYING;
                end
                ST_COUNT_IN: begin
                    if (tick_c) begin
                        if (cin_q == CIN_LAST) begin
                            state_d = ST_RECORDING;
                            cin_d   = '0;
                        end else begin
                            cin_d = cin_q + CIN_W'(1);
                        end
                    end
                end
                ST_PLAYING, ST_ARMED, ST_RECORDING: begin
                    // Pausing freezes the loop, so a coincident tick is dropped
                    if (play_btn) begin
                        state_d = ST_PAUSED;
                    end else begin
                        advance_c = tick_c;
                        if (rec_btn) begin
                            state_d = (state_q == ST_PLAYING) ? ST_ARMED : ST_PLAYING;
                        end else if (tick_c && (state_q == ST_ARMED) &&
                                     ((step_next_c & BAR_MASK) == '0)) begin
                            state_d = ST_RECORDING;
                        end else if (tick_c && (state_q == ST_RECORDING) &&
                                     (step_next_c == '0)) begin
                            state_d = ST_PLAYING;
                        end
                    end
                end
                default: state_d = ST_STOPPED;
            endcase
        end
        if (advance_c) step_d = step_next_c;
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_STOPPED;
            step_q      <= '0;
            cin_q       <= '0;
            tempo_q     <= TEMPO_RST;
            step_tick_q <= 1'b0;
            loop_wrap_q <= 1'b0;
            playing_q   <= 1'b0;
            recording_q <= 1'b0;
            armed_q     <= 1'b0;
            count_in_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cin_q       <= cin_d;
            tempo_q     <= tempo_d;
            step_tick_q <= advance_c;
            loop_wrap_q <= advance_c && (step_next_c == '0);
            playing_q   <= is_playing(state_d);
            recording_q <= (state_d == ST_RECORDING);
            armed_q     <= (state_d == ST_ARMED);
            count_in_q  <= (state_d == ST_COUNT_IN);
        end
    end

    assign step      = step_q;
    assign step_tick = step_tick_q;
    assign loop_wrap = loop_wrap_q;
    assign playing   = playing_q;
    assign recording = recording_q;
    assign armed     = armed_q;
    assign count_in  = count_in_q;
    assign tempo     = tempo_q;

endmodule

// File: tb/tb_transport_controller.sv
// Scoreboarded random/directed bench for transport_controller.
module tb_transport_controller;

    localparam int unsigned TEMPO_W = 33;
    localparam int T_DEF  = 3;
    localparam int T_MIN  = 2;
    localparam int T_MAX  = 6;
    localparam int STEP_W = 3;
    localparam int BAR    = 4;
    localparam int LOOP   = 1 << STEP_W;

    logic clock = 1'b0;
    logic resetn, play_btn, stop_btn, rec_btn, faster, slower;
    logic [STEP_W-1:0]  step;
    logic               step_tick, loop_wrap, playing, recording, armed, count_in;
    logic [TEMPO_W-1:0] tempo;

    transport_controller #(
        .TEMPO_W       (TEMPO_W),
        .TEMPO_DEFAULT (T_DEF),
        .TEMPO_MIN     (T_MIN),
        .TEMPO_MAX     (T_MAX),
        .STEP_W        (STEP_W),
        .BAR_STEPS     (BAR)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .play_btn  (play_btn),
        .stop_btn  (stop_btn),
        .rec_btn   (rec_btn),
        .faster    (faster),
        .slower    (slower),
        .step      (step),
        .step_tick (step_tick),
        .loop_wrap (loop_wrap),
        .playing   (playing),
        .recording (recording),
        .armed     (armed),
        .count_in  (count_in),
        .tempo     (tempo)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [STEP_W-1:0]  step;
        logic               tick;
        logic               wrap;
        logic               ply;
        logic               rec;
        logic               arm;
        logic               cin;
        logic [TEMPO_W-1:0] tempo;
    } snap_t;

    snap_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: transport mode plus plain integer counters
    typedef enum int {M_STOP, M_PAUSE, M_CIN, M_PLAY, M_ARM, M_REC} mode_t;
    mode_t m;
    int    m_step, m_timer, m_tempo, m_beats;
    bit    m_tick, m_wrap;

    task automatic model_reset();
        m       = M_STOP;
        m_step  = 0;
        m_timer = 0;
        m_tempo = T_DEF;
        m_beats = 0;
        m_tick  = 0;
        m_wrap  = 0;
    endtask

    // One clock of the transport as described by its rules
    task automatic model_cycle(input bit pl, input bit st, input bit rc,
                               input bit fa, input bit sl);
        bit fire;
        bit active;
        active = (m == M_CIN) || (m == M_PLAY) || (m == M_ARM) || (m == M_REC);
        fire   = 0;
        m_tick = 0;
        m_wrap = 0;
        if (active) begin
            if (m_timer == 0) begin
                fire    = 1;
                m_timer = m_tempo;
            end else begin
                m_timer = m_timer - 1;
            end
        end
        if (st) begin
            m       = M_STOP;
            m_step  = 0;
            m_timer = 0;
            m_beats = 0;
        end else begin
            case (m)
                M_STOP: begin
                    if (pl) begin
                        m = M_PLAY; m_timer = m_tempo;
                    end else if (rc) begin
                        m = M_CIN; m_timer = m_tempo; m_beats = 0;
                    end
                end
                M_PAUSE: begin
                    if (pl) begin
                        m = M_PLAY; m_timer = m_tempo;
                    end
                end
                M_CIN: begin
                    if (fire) begin
                        m_beats = m_beats + 1;
                        if (m_beats == BAR) begin
                            m = M_REC; m_beats = 0;
                        end
                    end
                end
                default: begin
                    if (pl) begin
                        m = M_PAUSE;
                    end else begin
                        if (fire) begin
                            m_step = (m_step + 1) % LOOP;
                            m_tick = 1;
                            m_wrap = (m_step == 0);
                        end
                        if (rc) m = (m == M_PLAY) ? M_ARM : M_PLAY;
                        else if (fire && m == M_ARM && (m_step % BAR) == 0) m = M_REC;
                        else if (fire && m == M_REC && m_step == 0) m = M_PLAY;
                    end
                end
            endcase
        end
        if (fa && !sl && m_tempo > T_MIN) m_tempo = m_tempo - 1;
        else if (sl && !fa && m_tempo < T_MAX) m_tempo = m_tempo + 1;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.step  = STEP_W'(m_step);
        s.tick  = m_tick;
        s.wrap  = m_wrap;
        s.ply   = (m == M_PLAY) || (m == M_ARM) || (m == M_REC);
        s.rec   = (m == M_REC);
        s.arm   = (m == M_ARM);
        s.cin   = (m == M_CIN);
        s.tempo = TEMPO_W'(m_tempo);
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after it
    task automatic cyc(input bit pl, input bit st, input bit rc, input bit fa, input bit sl);
        @(negedge clock);
        play_btn = pl;
        stop_btn = st;
        rec_btn  = rc;
        faster   = fa;
        slower   = sl;
        model_cycle(pl, st, rc, fa, sl);
        sb_q.push_back(model_snap());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic run_until_step(input int target, input string name);
        int n;
        n = 0;
        while (m_step != target && n < 200) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: step %0d not reached within 200 cycles", name, target);
        end
    endtask

    task automatic run_until_rec(input string name);
        int n;
        n = 0;
        while (m != M_REC && n < 200) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: recording not reached within 200 cycles", name);
        end
    endtask

    // Monitor: compare every output snapshot the DUT presents against the queue
    always @(posedge clock) begin
        #1;
        if (sb_q.size() != 0) begin
            snap_t e;
            snap_t a;
            e = sb_q.pop_front();
            a = {step, step_tick, loop_wrap, playing, recording, armed, count_in, tempo};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL snapshot t=%0t: got step=%0d tick=%0b wrap=%0b ply=%0b rec=%0b arm=%0b cin=%0b tempo=%0d, expected step=%0d tick=%0b wrap=%0b ply=%0b rec=%0b arm=%0b cin=%0b tempo=%0d",
                         $time, a.step, a.tick, a.wrap, a.ply, a.rec, a.arm, a.cin, a.tempo,
                         e.step, e.tick, e.wrap, e.ply, e.rec, e.arm, e.cin, e.tempo);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        play_btn = 0; stop_btn = 0; rec_btn = 0; faster = 0; slower = 0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_step", longint'(step), 0);
        chk("reset_tempo", longint'(tempo), T_DEF);
        chk("reset_status", longint'({step_tick, loop_wrap, playing, recording, armed, count_in}), 0);
        resetn = 1'b1;

        // Free-running play with default tempo: tick every 4 clocks, wrap at 8th
        cyc(1, 0, 0, 0, 0);
        idle(5);
        chk("first_tick_step", longint'(step), 1);
        chk("first_tick_pulse", longint'(step_tick), 1);
        idle(40);
        cyc(0, 1, 0, 0, 0);

        // Tempo saturation and hold
        repeat (5) cyc(0, 0, 0, 1, 0);
        idle(1);
        chk("tempo_floor", longint'(tempo), T_MIN);
        repeat (10) cyc(0, 0, 0, 0, 1);
        idle(1);
        chk("tempo_ceiling", longint'(tempo), T_MAX);
        repeat (5) cyc(0, 0, 0, 1, 1);
        idle(1);
        chk("tempo_both_hold", longint'(tempo), T_MAX);
        cyc(1, 0, 0, 0, 0);
        idle(20);
        repeat (4) cyc(0, 0, 0, 1, 0);
        idle(20);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        chk("tempo_back_to_3", longint'(tempo), 3);

        // Count-in then one full recorded loop
        cyc(0, 0, 1, 0, 0);
        idle(2);
        chk("count_in_flag", longint'(count_in), 1);
        chk("count_in_step", longint'(step), 0);
        idle(60);
        chk("after_loop_playing", longint'(playing), 1);
        chk("after_loop_recording", longint'(recording), 0);
        cyc(0, 1, 0, 0, 0);

        // Arm at step 1, record from bar line, punch out at step 6
        cyc(1, 0, 0, 0, 0);
        run_until_step(1, "arm_wait");
        cyc(0, 0, 1, 0, 0);
        idle(1);
        chk("armed_flag", longint'(armed), 1);
        run_until_step(6, "punch_wait");
        idle(1);
        chk("recording_at_6", longint'(recording), 1);
        cyc(0, 0, 1, 0, 0);
        idle(1);
        chk("punch_out_rec", longint'(recording), 0);
        chk("punch_out_play", longint'(playing), 1);

        // Pause at step 5, hold, resume
        run_until_step(5, "pause_wait");
        cyc(1, 0, 0, 0, 0);
        idle(20);
        chk("pause_step_hold", longint'(step), 5);
        chk("pause_not_playing", longint'(playing), 0);
        cyc(1, 0, 0, 0, 0);
        idle(5);
        chk("resume_step", longint'(step), 6);
        chk("resume_tick", longint'(step_tick), 1);

        // Stop + play + rec together while recording
        cyc(0, 0, 1, 0, 0);
        run_until_rec("stop_all_wait");
        cyc(1, 1, 1, 0, 0);
        idle(1);
        chk("stop_all_step", longint'(step), 0);
        chk("stop_all_playing", longint'(playing), 0);

        // Asynchronous reset while recording
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        run_until_rec("areset_wait");
        idle(3);
        @(negedge clock);
        chk("pre_reset_recording", longint'(recording), 1);
        resetn = 1'b0;
        #1;
        chk("areset_step", longint'(step), 0);
        chk("areset_status", longint'({step_tick, loop_wrap, playing, recording, armed, count_in}), 0);
        chk("areset_tempo", longint'(tempo), T_DEF);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;

        // Randomized commands and tempo nudges
        begin
            int hold;
            int tsel;
            hold = 0;
            tsel = 0;
            for (int i = 0; i < 3000; i++) begin
                bit pl;
                bit st;
                bit rc;
                pl = ($urandom_range(0, 29) == 0);
                st = ($urandom_range(0, 199) == 0);
                rc = ($urandom_range(0, 24) == 0);
                if (hold == 0) begin
                    hold = int'($urandom_range(1, 12));
                    tsel = int'($urandom_range(0, 5));
                end
                hold = hold - 1;
                cyc(pl, st, rc, (tsel == 1) || (tsel == 3), (tsel == 2) || (tsel == 3));
            end
        end

        idle(2);
        @(posedge clock);
        #2;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d snapshots left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/transport_controller.md
Name: transport_controller

Overview:
Sequences the beat-looper datapath. Owns the transport state machine (stopped / playing / paused / count-in / armed / recording), the tempo register and the step timer. Produces the step index and step strobe that drive the looper, the step display and the audio path. Replaces the free-running step counter and the ad-hoc tempo logic in the top level.

Parameters:
TEMPO_W, 33, width of the tempo (clocks-per-step) register
TEMPO_DEFAULT, 1687500, tempo after reset (clocks between steps minus 1)
TEMPO_MIN, 687500, fastest allowed tempo (saturation floor)
TEMPO_MAX, 4687500, slowest allowed tempo (saturation ceiling)
STEP_W, 7, step index width; the loop is 2**STEP_W steps
BAR_STEPS, 16, steps per bar (power of 2, ≤ 2**STEP_W)

Ports:
clock  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
play_btn  in  1  one-cycle pulse (debounced upstream): play/pause toggle
stop_btn  in  1  one-cycle pulse: stop and rewind
rec_btn  in  1  one-cycle pulse: record request / punch-out
faster  in  1  level: held = decrease tempo
slower  in  1  level: held = increase tempo
step  out  STEP_W  current step index
step_tick  out  1  one-cycle pulse on every step advance
loop_wrap  out  1  one-cycle pulse, coincident with step_tick, when step wraps to 0
playing  out  1  high in PLAYING, ARMED, RECORDING
recording  out  1  high in RECORDING only; looper write enable
armed  out  1  high in ARMED
count_in  out  1  high in COUNT_IN
tempo  out  TEMPO_W  current tempo register

Behaviour:
- Reset (async, resetn=0): state STOPPED; step=0; step_tick, loop_wrap, playing, recording, armed, count_in = 0; tempo=TEMPO_DEFAULT; timer=0.
- Command priority in one cycle: stop > play > rec. Lower-priority pulses in the same cycle are dropped.
- Tempo: faster-only → tempo-1 per clock, floored at TEMPO_MIN. Slower-only → tempo+1 per clock, capped at TEMPO_MAX. Both or neither → hold. Tempo is adjustable in every state.
- Step timer: down-counter, runs only in COUNT_IN, PLAYING, ARMED and RECORDING.
  - At 0: reload with current tempo and fire an internal tick.
  - Otherwise: decrement.
  - Entering a running state from STOPPED or PAUSED loads the timer with tempo, so the first tick comes tempo+1 clocks after the command.
  - A tempo change takes effect at the next reload.
- Tick in PLAYING, ARMED or RECORDING: step <= step+1 mod 2**STEP_W. step_tick=1 for that cycle. loop_wrap=1 if the new step is 0.
- State transitions:
  - STOPPED: play → PLAYING. rec → COUNT_IN (step stays 0, internal count-in counter = 0).
  - COUNT_IN: each tick increments the count-in counter and does not move step or pulse step_tick. On the BAR_STEPS-th tick → RECORDING, step stays 0 (no step_tick). play → ignored.
  - PLAYING: play → PAUSED. rec → ARMED.
  - ARMED: on a tick whose new step is a multiple of BAR_STEPS → RECORDING in the same cycle (recording goes high the cycle after that tick). rec → PLAYING (disarm).
  - RECORDING: on a tick that produces loop_wrap → PLAYING (one full loop recorded). rec → PLAYING immediately (punch-out). play → PAUSED.
  - PAUSED: step and timer frozen, all status outputs 0. play → PLAYING (timer reloaded). rec → ignored.
  - stop from any state → STOPPED, step=0, timer=0. A tick in the same cycle is discarded.
- Outputs are registered. Status outputs decode the registered state.

Decomposition:
- Package transport_pkg: state enum (STOPPED, PAUSED, COUNT_IN, PLAYING, ARMED, RECORDING) and the default tempo constants.
- Sub-module step_timer: loadable down-counter with run, load and tick. The transport FSM, tempo register and step counter stay in transport_controller.

Test Plan:
Bench parameters: TEMPO_DEFAULT=3, TEMPO_MIN=2, TEMPO_MAX=6, STEP_W=3, BAR_STEPS=4.
- Reset then play at cycle 0 → step_tick at cycles 4, 8, 12…; step 1, 2, 3…; at the 8th tick step=0 with loop_wrap=1.
- Hold faster 5 clocks from tempo 3 → tempo 2, saturates. Hold slower 10 clocks → tempo 6, saturates. Both held → unchanged. Tick spacing follows the new tempo after the next reload.
- STOPPED, rec → count_in=1 for 4 ticks with step=0 and no step_tick. Then recording=1 from step 0, returning to playing after 8 ticks (loop_wrap).
- PLAYING at step 1, rec → armed=1. At the tick to step 4, recording=1 next cycle. rec pulse at step 6 → recording=0 next cycle, playing=1.
- play at step 5 → PAUSED, step holds 5 for 20 cycles. play again → next step_tick 4 cycles later, step=6.
- stop, play and rec in the same cycle during RECORDING → STOPPED, step=0. resetn low mid-RECORDING → all outputs to reset values immediately, no clock needed.
